load_store_unit: RTL and testbench

Memory-stage load/store unit that sits between the EX/MEM pipeline register and the data memory. It turns one pipeline load or store into one or more word-addressed memory operations. It splits misaligned halfword/word accesses into sequential aligned operations and stalls the pipeline while it does so. It also formats load results (lane extraction, sign/zero extension) for writeback.

---
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: splits misaligned halfword/word accesses into
// aligned memory operations, stalls the pipeline meanwhile, and formats load data.
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic        i_req_write,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_lsu_stall,
  output logic        o_load_done,
  output logic [31:0] o_load_data,
  output logic        o_mem_write,
  output logic [2:0]  o_mem_funct3,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {StIdle, StLdHi, StStBytes} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic [31:0] r_lo_word, w_lo_word_next;
  logic [1:0]  r_cnt, w_cnt_next;
  logic        w_latch;

  logic        w_misaligned;
  logic [31:0] w_aligned_lane;
  logic [31:0] w_split_lane;
  logic [7:0]  w_st_byte;
  logic        w_last_byte;

  // funct3[1:0] of 10 or 11 is a word access; bytes are never misaligned.
  assign w_misaligned = (i_req_funct3[1:0] == 2'b01) ? i_req_addr[0] :
                        (i_req_funct3[1] ? (i_req_addr[1:0] != 2'b00) : 1'b0);

  assign w_aligned_lane = i_mem_rdata >> {i_req_addr[1:0], 3'b000};
  assign w_split_lane   = 32'({i_mem_rdata, r_lo_word} >> {r_addr[1:0], 3'b000});
  assign w_st_byte      = 8'(r_wdata >> {r_cnt, 3'b000});
  assign w_last_byte    = (r_funct3[1:0] == 2'b01) ? (r_cnt == 2'd1) : (r_cnt == 2'd3);

  function automatic logic [31:0] fmt_load(input logic [31:0] lane, input logic [2:0] f3);
    logic [31:0] res;
    case (f3[1:0])
      2'b00:   res = f3[2] ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   res = f3[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_lo_word_next = r_lo_word;
    w_latch        = 1'b0;
    o_lsu_stall    = 1'b0;
    o_load_done    = 1'b0;
    o_load_data    = 32'b0;
    o_mem_write    = 1'b0;
    o_mem_funct3   = i_req_funct3;
    o_mem_addr     = i_req_addr;
    o_mem_wdata    = i_req_wdata;

    case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          if (!w_misaligned) begin
            o_mem_write = i_req_write;
            o_load_done = 1'b1;
            o_load_data = i_req_write ? 32'b0 : fmt_load(w_aligned_lane, i_req_funct3);
          end else if (!i_req_write) begin
            o_mem_funct3   = 3'b010;
            o_mem_addr     = {i_req_addr[31:2], 2'b00};
            w_lo_word_next = i_mem_rdata;
            w_latch        = 1'b1;
            o_lsu_stall    = 1'b1;
            w_state_next   = StLdHi;
          end else begin
            o_mem_funct3 = 3'b000;
            o_mem_wdata  = {24'b0, i_req_wdata[7:0]};
            o_mem_write  = 1'b1;
            w_latch      = 1'b1;
            w_cnt_next   = 2'd1;
            o_lsu_stall  = 1'b1;
            w_state_next = StStBytes;
          end
        end
      end
      StLdHi: begin
        o_mem_funct3 = 3'b010;
        o_mem_addr   = {r_addr[31:2], 2'b00} + 32'd4;
        o_mem_wdata  = 32'b0;
        o_load_data  = fmt_load(w_split_lane, r_funct3);
        o_load_done  = 1'b1;
        w_state_next = StIdle;
      end
      StStBytes: begin
        o_mem_funct3 = 3'b000;
        o_mem_addr   = r_addr + {30'b0, r_cnt};
        o_mem_wdata  = {24'b0, w_st_byte};
        o_mem_write  = 1'b1;
        w_cnt_next   = r_cnt + 2'd1;
        if (w_last_byte) begin
          o_load_done  = 1'b1;
          w_state_next = StIdle;
        end else begin
          o_lsu_stall = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase

    // Reset blocks any memory side effect in the cycle it is asserted.
    if (i_rst) begin
      o_lsu_stall = 1'b0;
      o_load_done = 1'b0;
      o_load_data = 32'b0;
      o_mem_write = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_cnt     <= 2'd0;
      r_lo_word <= 32'b0;
      r_addr    <= 32'b0;
      r_funct3  <= 3'b0;
      r_wdata   <= 32'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_lo_word <= w_lo_word_next;
      if (w_latch) begin
        r_addr   <= i_req_addr;
        r_funct3 <= i_req_funct3;
        r_wdata  <= i_req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16-byte data memory model and a
// scoreboard of expected completions and memory addresses.
module tb_load_store_unit;

  logic        clk, rst;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        lsu_stall, load_done;
  logic [31:0] load_data;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [4];
  logic        do_preload;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        is_load;
    int          ncyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  load_store_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_write  (req_write),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_lsu_stall  (lsu_stall),
    .o_load_done  (load_done),
    .o_load_data  (load_data),
    .o_mem_write  (mem_write),
    .o_mem_funct3 (mem_funct3),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Words 0..3 are RAM; everything else is unmapped and reads as zero.
  assign mem_rdata = (mem_addr[31:4] == 28'b0) ? mem[mem_addr[3:2]] : 32'b0;

  always @(posedge clk) begin
    if (do_preload) begin
      mem[0] <= 32'h44332211;
      mem[1] <= 32'h88776655;
      mem[2] <= 32'h0;
      mem[3] <= 32'h0;
    end else if (mem_write && mem_addr[31:4] == 28'b0) begin
      case (mem_funct3[1:0])
        2'b00:   mem[mem_addr[3:2]][{mem_addr[1:0], 3'b000} +: 8]  <= mem_wdata[7:0];
        2'b01:   mem[mem_addr[3:2]][{mem_addr[1:0], 3'b000} +: 16] <= mem_wdata[15:0];
        default: mem[mem_addr[3:2]] <= mem_wdata;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload();
    req_valid  = 1'b0;
    do_preload = 1'b1;
    @(posedge clk); #1;
    do_preload = 1'b0;
  endtask

  // Drives one request and follows it to completion; addr_q holds the expected
  // per-cycle mem_addr sequence pushed by the caller.
  task automatic do_op(input string tag, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_data, input int ncyc);
    exp_t e;
    bit   done;
    int   c;
    e.data = exp_data;
    e.is_load = !wr;
    e.ncyc = ncyc;
    exp_q.push_back(e);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    done = 0;
    c = 0;
    while (!done && c < 8) begin
      @(negedge clk);
      c++;
      if (addr_q.size() > 0) chk({tag, ".addr"}, mem_addr, addr_q.pop_front());
      chk({tag, ".wr"}, {31'b0, mem_write}, {31'b0, wr});
      if (load_done) begin
        e = exp_q.pop_front();
        chk({tag, ".cycles"}, c, e.ncyc);
        chk({tag, ".stall_end"}, {31'b0, lsu_stall}, 32'd0);
        if (e.is_load) chk({tag, ".data"}, load_data, e.data);
        done = 1;
      end else begin
        chk({tag, ".stall"}, {31'b0, lsu_stall}, 32'd1);
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL %s.timeout: observed=no load_done expected=done within 8 cycles", tag);
      exp_q.delete();
    end
    addr_q.delete();
    req_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    do_preload = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h2;
    req_wdata  = 32'h0;

    // Reset with a misaligned request pending: outputs must be quiet.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.stall", {31'b0, lsu_stall}, 32'd0);
    chk("rst.done", {31'b0, load_done}, 32'd0);
    chk("rst.wr", {31'b0, mem_write}, 32'd0);
    chk("rst.data", load_data, 32'd0);
    @(posedge clk); #1;
    preload();
    rst = 1'b0;

    addr_q.push_back(32'h0);
    do_op("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h44332211, 1);
    addr_q.push_back(32'h7);
    do_op("lb7", 1'b0, 3'b000, 32'h7, 32'h0, 32'hFFFFFF88, 1);
    addr_q.push_back(32'h7);
    do_op("lbu7", 1'b0, 3'b100, 32'h7, 32'h0, 32'h00000088, 1);
    addr_q.push_back(32'h2);
    do_op("lh2", 1'b0, 3'b001, 32'h2, 32'h0, 32'h00004433, 1);
    addr_q.push_back(32'h6);
    do_op("lh6", 1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF8877, 1);
    addr_q.push_back(32'h0); addr_q.push_back(32'h4);
    do_op("lw2", 1'b0, 3'b010, 32'h2, 32'h0, 32'h66554433, 2);
    addr_q.push_back(32'h0); addr_q.push_back(32'h4);
    do_op("lh3", 1'b0, 3'b001, 32'h3, 32'h0, 32'h00005544, 2);

    addr_q.push_back(32'h1); addr_q.push_back(32'h2);
    addr_q.push_back(32'h3); addr_q.push_back(32'h4);
    do_op("sw1", 1'b1, 3'b010, 32'h1, 32'hAABBCCDD, 32'h0, 4);
    chk("sw1.word0", mem[0], 32'hBBCCDD11);
    chk("sw1.word1", mem[1], 32'h887766AA);

    preload();
    addr_q.push_back(32'h3); addr_q.push_back(32'h4);
    do_op("sh3", 1'b1, 3'b001, 32'h3, 32'h0000BEEF, 32'h0, 2);
    addr_q.push_back(32'h0);
    do_op("lw0b2b", 1'b0, 3'b010, 32'h0, 32'h0, 32'hEF332211, 1);
    chk("sh3.word0", mem[0], 32'hEF332211);
    chk("sh3.word1", mem[1], 32'h887766BE);

    addr_q.push_back(32'h8);
    do_op("sw8", 1'b1, 3'b010, 32'h8, 32'h12345678, 32'h0, 1);
    chk("sw8.word2", mem[2], 32'h12345678);

    // High half comes from address 0 after wrapping; low word is unmapped.
    addr_q.push_back(32'hFFFFFFFC); addr_q.push_back(32'h0);
    do_op("lwwrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h22110000, 2);

    // Reset after two bytes of a split word store.
    preload();
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h1;
    req_wdata  = 32'hAABBCCDD;
    @(negedge clk);
    chk("rstmid.b0.wr", {31'b0, mem_write}, 32'd1);
    chk("rstmid.b0.addr", mem_addr, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid.b1.wr", {31'b0, mem_write}, 32'd1);
    chk("rstmid.b1.addr", mem_addr, 32'h2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.rst.wr", {31'b0, mem_write}, 32'd0);
    chk("rstmid.rst.stall", {31'b0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid.after.wr", {31'b0, mem_write}, 32'd0);
    chk("rstmid.after.stall", {31'b0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    chk("rstmid.word0", mem[0], 32'h44CCDD11);
    chk("rstmid.word1", mem[1], 32'h88776655);
    addr_q.push_back(32'h0);
    do_op("rstmid.lw0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h44CCDD11, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
